skewed_operand_bram: RTL and testbench

- Single-port synchronous block memory that feeds one row or column lane of the 4x4 systolic matrix multiplier.
- Power-up contents are a time-skewed operand stream: lane L holds its 4 operands starting at address L, with zeros elsewhere.
- The array controller sweeps the address 0..9 and streams `douta` straight into the edge processing element.
- Separate instances, one per lane, differ only in the LANE parameter.

---
 rtl/skewed_operand_bram.sv | 147 ++++++++++++++
 tb/tb_skewed_operand_bram.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/skewed_operand_bram.sv
// ---------------------------------------------------------------------------
// skewed_operand_bram
//
// Single-port synchronous block memory that feeds one edge lane of the 4x4
// systolic matrix multiplier. At power-up it holds a diagonally skewed
// operand stream: lane L keeps its four operands at addresses L..L+3 and
// zeros everywhere else, so a plain 0..9 address sweep delivers the operands
// to the edge processing element with the one-cycle-per-lane stagger the
// array needs.
//
// Parameters:
//   DATA_WIDTH - width of dina/douta and of each stored word
//   ADDR_WIDTH - word address width, DEPTH = 2**ADDR_WIDTH
//   LANE       - lane index 0..3, selects skew offset and operand block
//   SKEW_EN    - 1 = preload skewed operand image, 0 = preload zeros
//
// Ports:
//   clk   - clock, all memory activity on the rising edge
//   rst   - asynchronous active-high reset, clears the output register only
//   ena   - port enable, gates both read and write
//   wea   - write enable, qualified by ena
//   addra - word address
//   dina  - write data
//   douta - registered read data, write-first, one cycle latency
// ---------------------------------------------------------------------------
module skewed_operand_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int LANE       = 0,
    parameter int SKEW_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int LANE_OPS  = 4;
    localparam int IMG_WIDTH = DEPTH * DATA_WIDTH;

    // Builds the power-up image: word[LANE+j] = LANE*4 + j + 1, zero elsewhere.
    // Words that would fall past the top of a shallow memory are dropped.
    function automatic logic [IMG_WIDTH-1:0] init_image();
        logic [IMG_WIDTH-1:0] img_s;
        img_s = {IMG_WIDTH{1'b0}};
        if (SKEW_EN != 0) begin
            for (int j = 0; j < LANE_OPS; j++) begin
                if ((LANE + j) < DEPTH) begin
                    img_s[(LANE + j) * DATA_WIDTH +: DATA_WIDTH] =
                        DATA_WIDTH'(LANE * LANE_OPS + j + 1);
                end else begin
                    img_s = img_s;
                end
            end
        end else begin
            img_s = {IMG_WIDTH{1'b0}};
        end
        return img_s;
    endfunction

    // Storage array; contents come only from the power-up image and writes,
    // reset never touches them.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_r = init_image();

    // Output register powers up at zero so the edge PE sees no stray operand.
    logic [DATA_WIDTH-1:0] dout_r = {DATA_WIDTH{1'b0}};

    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Write qualification and write-first read data selection.
    always_comb begin
        wr_en_s   = 1'b0;
        rd_data_s = mem_r[addra];
        if (ena && wea && !rst) begin
            wr_en_s   = 1'b1;
            rd_data_s = dina;
        end else begin
            wr_en_s   = 1'b0;
            rd_data_s = mem_r[addra];
        end
    end

    // Memory write port; rst sampled high at the edge blocks the write.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[addra] <= dina;
        end
    end

    // Registered read port; reset clears it immediately, ena=0 holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r <= {DATA_WIDTH{1'b0}};
        end else if (ena) begin
            dout_r <= rd_data_s;
        end
    end

    assign douta = dout_r;

    skewed_operand_bram_chk #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_chk (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .wea  (wea),
        .dina (dina),
        .douta(douta)
    );

endmodule

// ---------------------------------------------------------------------------
// skewed_operand_bram_chk
//
// Protocol checker for the lane memory output register.
//
// Ports (all inputs): clk, rst, ena, wea, dina, douta - mirror the memory.
// ---------------------------------------------------------------------------
module skewed_operand_bram_chk #(
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  ena,
    input logic                  wea,
    input logic [DATA_WIDTH-1:0] dina,
    input logic [DATA_WIDTH-1:0] douta
);

    // A disabled port must leave the output register untouched.
    a_hold_when_disabled: assert property (
        @(posedge clk) disable iff (rst) !ena |=> $stable(douta)
    );

    // A write shows the written data on the output the same edge.
    a_write_first: assert property (
        @(posedge clk) disable iff (rst) (ena && wea) |=> (douta == $past(dina))
    );

endmodule

// File: tb/tb_skewed_operand_bram.sv
// ---------------------------------------------------------------------------
// tb_skewed_operand_bram
//
// Drives four skewed lanes (LANE 0..3) and one unskewed instance from shared
// stimulus and compares every output against hand-computed values.
// ---------------------------------------------------------------------------
module tb_skewed_operand_bram;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic [DW-1:0] dout0, dout1, dout2, dout3, dout_z;

    int total_checks;
    int passed_checks;

    skewed_operand_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE(0), .SKEW_EN(1)) u_l0 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout0));
    skewed_operand_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE(1), .SKEW_EN(1)) u_l1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout1));
    skewed_operand_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE(2), .SKEW_EN(1)) u_l2 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout2));
    skewed_operand_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE(3), .SKEW_EN(1)) u_l3 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout3));
    skewed_operand_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE(2), .SKEW_EN(0)) u_z (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_z));

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          ena;
        logic          wea;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        logic [DW-1:0] exp3;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic e, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                           input logic [DW-1:0] x2, input logic [DW-1:0] x3);
        vec_t v;
        v.name = name; v.ena = e; v.wea = w; v.addr = a; v.din = d;
        v.exp0 = x0; v.exp1 = x1; v.exp2 = x2; v.exp3 = x3;
        vecs.push_back(v);
    endtask

    // Apply inputs, let one rising edge pass, sample 1 ns later.
    task automatic cycle(input logic e, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ena = e; wea = w; addra = a; dina = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst   = 1'b0;
        ena   = 1'b0;
        wea   = 1'b0;
        addra = 4'd0;
        dina  = 32'd0;

        // Sweep 0..9: douta one cycle late equals word[addr] of each lane.
        add_vec("sweep0", 1'b1, 1'b0, 4'd0, 32'd0, 32'd1, 32'd0, 32'd0,  32'd0);
        add_vec("sweep1", 1'b1, 1'b0, 4'd1, 32'd0, 32'd2, 32'd5, 32'd0,  32'd0);
        add_vec("sweep2", 1'b1, 1'b0, 4'd2, 32'd0, 32'd3, 32'd6, 32'd9,  32'd0);
        add_vec("sweep3", 1'b1, 1'b0, 4'd3, 32'd0, 32'd4, 32'd7, 32'd10, 32'd13);
        add_vec("sweep4", 1'b1, 1'b0, 4'd4, 32'd0, 32'd0, 32'd8, 32'd11, 32'd14);
        add_vec("sweep5", 1'b1, 1'b0, 4'd5, 32'd0, 32'd0, 32'd0, 32'd12, 32'd15);
        add_vec("sweep6", 1'b1, 1'b0, 4'd6, 32'd0, 32'd0, 32'd0, 32'd0,  32'd16);
        add_vec("sweep7", 1'b1, 1'b0, 4'd7, 32'd0, 32'd0, 32'd0, 32'd0,  32'd0);
        add_vec("sweep8", 1'b1, 1'b0, 4'd8, 32'd0, 32'd0, 32'd0, 32'd0,  32'd0);
        add_vec("sweep9", 1'b1, 1'b0, 4'd9, 32'd0, 32'd0, 32'd0, 32'd0,  32'd0);
        // Write-first, read-back, then a preloaded word on lane0.
        add_vec("wr_first",  1'b1, 1'b1, 4'd9, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        add_vec("wr_readbk", 1'b1, 1'b0, 4'd9, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        add_vec("rd_addr0",  1'b1, 1'b0, 4'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0);
        // Disabled port: no write, output holds.
        add_vec("dis_hold",  1'b0, 1'b1, 4'd2, 32'd55, 32'd1, 32'd0, 32'd0, 32'd0);
        add_vec("dis_nowr",  1'b1, 1'b0, 4'd2, 32'd0, 32'd3, 32'd6, 32'd9, 32'd0);
        add_vec("dis_hold2", 1'b0, 1'b0, 4'd7, 32'd0, 32'd3, 32'd6, 32'd9, 32'd0);
        // Write at a high address, move away, come back.
        add_vec("wr12",      1'b1, 1'b1, 4'd12, 32'h01234567, 32'h01234567, 32'h01234567, 32'h01234567, 32'h01234567);
        add_vec("rd5",       1'b1, 1'b0, 4'd5, 32'd0, 32'd0, 32'd0, 32'd12, 32'd15);
        add_vec("rd12",      1'b1, 1'b0, 4'd12, 32'd0, 32'h01234567, 32'h01234567, 32'h01234567, 32'h01234567);
        add_vec("rd15",      1'b1, 1'b0, 4'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Power-up value before any clock edge.
        #1;
        check("powerup_l0", dout0, 32'd0);
        check("powerup_l3", dout3, 32'd0);

        // Reset pulse, then release away from an edge.
        rst = 1'b1;
        #1;
        check("reset_l1", dout1, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unskewed instance reads zero everywhere (before any write).
        for (int a = 0; a < 16; a++) begin
            cycle(1'b1, 1'b0, AW'(a), 32'd0);
            check($sformatf("noskew_a%0d", a), dout_z, 32'd0);
        end

        // Table-driven vectors.
        foreach (vecs[i]) begin
            cycle(vecs[i].ena, vecs[i].wea, vecs[i].addr, vecs[i].din);
            check({vecs[i].name, "_l0"}, dout0, vecs[i].exp0);
            check({vecs[i].name, "_l1"}, dout1, vecs[i].exp1);
            check({vecs[i].name, "_l2"}, dout2, vecs[i].exp2);
            check({vecs[i].name, "_l3"}, dout3, vecs[i].exp3);
        end

        // Asynchronous reset mid-sweep on lane2 reading address 3.
        cycle(1'b1, 1'b0, 4'd3, 32'd0);
        check("arst_pre_l2", dout2, 32'd10);
        #2;
        rst = 1'b1;
        #1;
        check("arst_now_l2", dout2, 32'd0);
        check("arst_now_l0", dout0, 32'd0);
        // Write attempt while in reset must be blocked.
        cycle(1'b1, 1'b1, 4'd3, 32'd99);
        check("arst_held_l2", dout2, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Disabled edge after release: still zero.
        cycle(1'b0, 1'b0, 4'd3, 32'd0);
        check("arst_dis_l2", dout2, 32'd0);
        // First enabled read shows retained contents.
        cycle(1'b1, 1'b0, 4'd3, 32'd0);
        check("arst_post_l2", dout2, 32'd10);
        check("arst_post_l3", dout3, 32'd13);
        check("arst_post_l1", dout1, 32'd7);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
